mac_unit: RTL and testbench
===========================

Name: mac_unit

Overview:
- Sequential dot-product engine: computes sum of wt[i]*x[i] for i=1..num_mul using one multiplier and one accumulator, one term per clock.
- Sits after the counter/RAM loader. That path fills the wt/x operand arrays from the 32-bit data bus.
- On a start trigger, snapshots the operand arrays, accumulates, then presents a word_size result and a one-cycle finish strobe.

Parameters:
word_size  16  operand and result width (bits)
bus_width  32  accumulator width; also width of the observed data bus
num_mul  12  number of wt/x pairs (array index range num_mul down to 1)

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous, active-high reset
wt  input  word_size x [num_mul:1]  weight operand array (unpacked)
x  input  word_size x [num_mul:1]  data operand array (unpacked)
en  input  1  global enable; low freezes all internal state
start  input  1  start request, rising-edge triggered
opt  output  word_size  result: low word_size bits of the accumulated sum
finish  output  1  one-cycle completion strobe
bus  input  bus_width  loader data bus ({wt,x} pair); monitored only, no effect on datapath or outputs

Behaviour:
- Reset:
  - Sampled on posedge clk when rst=1.
  - Sets state=IDLE, opt=0, finish=0, buffer (accumulator)=0, idx=1, start_q=0.
  - Clears wt_buff and x_buff to 0.
  - Overrides en and start. Aborts any operation in progress; no finish is produced for the aborted run.
- Start detect:
  - start_q is a register of start, updated every enabled cycle.
  - Trigger = start & ~start_q & en & (state==IDLE).
  - start held high triggers once only. start edges outside IDLE are ignored and not queued.
- States: IDLE, ACC.
- IDLE:
  - finish=0.
  - On trigger at edge N: copy wt[1..num_mul] into wt_buff and x[1..num_mul] into x_buff; clear buffer to 0; set idx=1; go to ACC.
- ACC:
  - Each enabled edge: buffer <= buffer + wt_buff[idx]*x_buff[idx]; idx <= idx+1.
  - At the edge with idx==num_mul, in the same edge: opt <= low word_size bits of (buffer + last product); finish <= 1; state <= IDLE.
  - Operand changes on wt/x during ACC have no effect, because buffers are used.
- Latency: trigger sampled at edge N gives finish=1 and a valid opt after edge N+num_mul (12 cycles with default parameters). finish returns to 0 after edge N+num_mul+1.
- Arithmetic:
  - Unsigned throughout.
  - Product width is 2*word_size.
  - Accumulation is modulo 2^bus_width.
  - opt = buffer[word_size-1:0], truncated with no saturation.
- opt holds its value until the next completion or reset.
- en=0: state, idx, buffer, opt and start_q all hold. A finish=1 already asserted holds until the next enabled edge. Each en=0 cycle during ACC extends latency by one cycle.
- Back-to-back: a new rising start edge is accepted in IDLE on the edge after finish.
- rst and trigger on the same edge: reset wins.

Test Plan:
- wt[1]=13, wt[2]=17, x[1]=6, x[2]=10, others 0; en=1; pulse start -> finish high exactly 12 cycles after the trigger edge, opt=248, finish low the following cycle.
- All wt=1, all x=1; start -> opt=12. Then change wt/x to 0 mid-ACC -> opt still 12.
- All wt=x=16'hFFFF; start -> opt=16'h000C (accumulator wraps modulo 2^32 to 32'hFFE8000C).
- Hold start high for 40 cycles with wt=x=2 -> exactly one finish pulse, opt=48. Drop start and raise it again -> second run, opt=48.
- Drive en=0 for 3 cycles mid-ACC -> finish arrives 15 cycles after trigger, opt unchanged in value. Toggle bus arbitrarily throughout -> no effect on opt or finish.
- Assert rst at cycle 5 of ACC -> opt=0, finish stays 0, no completion. A subsequent start yields the correct sum after 12 cycles.

Source files
------------

// File: rtl/mac_unit_if.sv
// Operand/result bundle between the loader side and the dot-product engine.
// The loader (master) drives the operand arrays, enable, start and the observed
// data bus; the engine (slave) returns the result word and its finish strobe.
interface mac_unit_if #(
    parameter int word_size = 16,
    parameter int bus_width = 32,
    parameter int num_mul   = 12
);
    logic [word_size-1:0] wt [num_mul:1];
    logic [word_size-1:0] x  [num_mul:1];
    logic                 en;
    logic                 start;
    logic [bus_width-1:0] bus;
    logic [word_size-1:0] opt;
    logic                 finish;

    modport master (output wt, x, en, start, bus, input opt, finish);
    modport slave  (input wt, x, en, start, bus, output opt, finish);
endinterface

// File: rtl/mac_unit.sv
// Sequential dot-product engine: one multiply-accumulate per enabled clock.
// Handshake: a rising edge on start while idle and enabled snapshots the operand
// arrays; num_mul enabled cycles later finish pulses for one enabled cycle with
// opt valid, and opt then holds until the next completion or reset.
module mac_unit #(
    parameter int word_size = 16,
    parameter int bus_width = 32,
    parameter int num_mul   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_unit_if.slave            io,
    output logic                 dbg_state,
    output logic [bus_width-1:0] dbg_bus
);
    localparam int idx_w = $clog2(num_mul + 1);

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [idx_w-1:0]       idx_q;
    logic [bus_width-1:0]   buffer_q;
    logic [bus_width-1:0]   sum;
    logic [2*word_size-1:0] prod;
    logic [word_size-1:0]   wt_buff [num_mul:1];
    logic [word_size-1:0]   x_buff  [num_mul:1];
    logic [word_size-1:0]   opt_q;
    logic                   finish_q;
    logic                   start_q;
    logic                   trigger;
    logic                   last;
    logic [bus_width-1:0]   bus_q;

    // Next-state logic, start-edge detect and the multiply-add term.
    always_comb begin
        state_d = state_q;
        trigger = 1'b0;
        last    = 1'b0;
        prod    = {{word_size{1'b0}}, wt_buff[idx_q]} * {{word_size{1'b0}}, x_buff[idx_q]};
        sum     = buffer_q + bus_width'(prod);
        case (state_q)
            IDLE: begin
                trigger = io.start & ~start_q & io.en;
                if (trigger) state_d = ACC;
            end
            ACC: begin
                last = io.en & (idx_q == idx_w'(num_mul));
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; a disabled cycle freezes the FSM.
    always_ff @(posedge clk) begin
        if (rst)        state_q <= IDLE;
        else if (io.en) state_q <= state_d;
    end

    // Operand snapshot, accumulator, index, result and finish strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            opt_q    <= '0;
            finish_q <= 1'b0;
            buffer_q <= '0;
            idx_q    <= idx_w'(1);
            start_q  <= 1'b0;
            for (int i = 1; i <= num_mul; i++) begin
                wt_buff[i] <= '0;
                x_buff[i]  <= '0;
            end
        end else if (io.en) begin
            start_q  <= io.start;
            finish_q <= last;
            if (trigger) begin
                wt_buff  <= io.wt;
                x_buff   <= io.x;
                buffer_q <= '0;
                idx_q    <= idx_w'(1);
            end else if (state_q == ACC) begin
                buffer_q <= sum;
                idx_q    <= idx_q + idx_w'(1);
                if (last) opt_q <= sum[word_size-1:0];
            end
        end
    end

    // Loader bus is only observed; its last value is exposed for debug.
    always_ff @(posedge clk) begin
        if (rst) bus_q <= '0;
        else     bus_q <= io.bus;
    end

    assign io.opt    = opt_q;
    assign io.finish = finish_q;
    assign dbg_state = (state_q == ACC);
    assign dbg_bus   = bus_q;
endmodule

// File: tb/tb_mac_unit.sv
// Directed-plus-random bench for mac_unit with a plain-arithmetic dot-product model.
module tb_mac_unit;
    localparam int WS = 16;
    localparam int BW = 32;
    localparam int NM = 12;

    logic          clk;
    logic          rst;
    logic          dbg_state;
    logic [BW-1:0] dbg_bus;

    int checks = 0;
    int errors = 0;

    logic [WS-1:0] wt_m [NM:1];
    logic [WS-1:0] x_m  [NM:1];

    mac_unit_if #(.word_size(WS), .bus_width(BW), .num_mul(NM)) mif ();

    mac_unit #(.word_size(WS), .bus_width(BW), .num_mul(NM)) dut (
        .clk       (clk),
        .rst       (rst),
        .io        (mif),
        .dbg_state (dbg_state),
        .dbg_bus   (dbg_bus)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum of products modulo 2^32, low word of the result.
    function automatic logic [WS-1:0] ref_dot();
        longint unsigned acc = 0;
        for (int i = 1; i <= NM; i++) begin
            acc = (acc + longint'(wt_m[i]) * longint'(x_m[i])) & 64'hFFFF_FFFF;
        end
        return acc[WS-1:0];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        mif.bus = $urandom;
    endtask

    task automatic apply();
        for (int i = 1; i <= NM; i++) begin
            mif.wt[i] = wt_m[i];
            mif.x[i]  = x_m[i];
        end
    endtask

    task automatic fill(logic [WS-1:0] w, logic [WS-1:0] v);
        for (int i = 1; i <= NM; i++) begin
            wt_m[i] = w;
            x_m[i]  = v;
        end
    endtask

    task automatic fill_random();
        for (int i = 1; i <= NM; i++) begin
            wt_m[i] = WS'($urandom);
            x_m[i]  = WS'($urandom);
        end
    endtask

    // One run: trigger, optional en gap / operand scramble, check latency, result, strobe drop.
    task automatic run(string tag, int gap_at, int gap_len, int zero_at, int exp_lat);
        logic [WS-1:0] exp = ref_dot();
        int cnt = 0;
        apply();
        mif.en    = 1'b1;
        mif.start = 1'b1;
        step();
        mif.start = 1'b0;
        while (mif.finish !== 1'b1 && cnt < 60) begin
            if (cnt == zero_at) begin
                for (int i = 1; i <= NM; i++) begin
                    mif.wt[i] = '0;
                    mif.x[i]  = '0;
                end
            end
            mif.en = (cnt >= gap_at && cnt < gap_at + gap_len) ? 1'b0 : 1'b1;
            step();
            cnt++;
        end
        mif.en = 1'b1;
        check({tag, "_lat"}, cnt, exp_lat);
        check({tag, "_opt"}, mif.opt, exp);
        step();
        check({tag, "_fin_drop"}, mif.finish, 1'b0);
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        mif.en    = 1'b0;
        mif.start = 1'b0;
        mif.bus   = '0;
        fill('0, '0);
        apply();
        step(); step(); step();
        rst = 1'b0;
        mif.en = 1'b1;
        step();
        check("rst_opt", mif.opt, 0);
        check("rst_finish", mif.finish, 0);
        check("rst_state", dbg_state, 0);

        // Two nonzero pairs
        fill('0, '0);
        wt_m[1] = 13; wt_m[2] = 17; x_m[1] = 6; x_m[2] = 10;
        run("basic", 99, 0, 99, NM);
        check("basic_const", mif.opt, 248);

        // Operand change mid-accumulation must not matter
        fill(1, 1);
        run("buffered", 99, 0, 5, NM);
        check("buffered_const", mif.opt, 12);

        // Wraparound of the 32-bit accumulator
        fill(16'hFFFF, 16'hFFFF);
        run("wrap", 99, 0, 99, NM);
        check("wrap_const", mif.opt, 16'h000C);

        // start held high: single trigger
        fill(2, 2);
        apply();
        mif.start = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (mif.finish === 1'b1) pulses++;
        end
        check("held_pulses", pulses, 1);
        check("held_opt", mif.opt, 48);
        mif.start = 1'b0;
        step();
        run("held_rerun", 99, 0, 99, NM);

        // Three disabled cycles mid-run
        fill_random();
        run("en_gap", 4, 3, 99, NM + 3);

        // Reset during accumulation aborts the run
        fill_random();
        apply();
        mif.start = 1'b1;
        step();
        mif.start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_opt", mif.opt, 0);
        check("abort_finish", mif.finish, 0);
        check("abort_state", dbg_state, 0);
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (mif.finish === 1'b1) pulses++;
        end
        check("abort_no_finish", pulses, 0);
        fill_random();
        run("after_abort", 99, 0, 99, NM);

        // Random operands with random enable gaps
        for (int r = 0; r < 6; r++) begin
            int gl;
            int ga;
            gl = $urandom_range(0, 3);
            ga = $urandom_range(1, 8);
            fill_random();
            run($sformatf("rand%0d", r), ga, gl, 99, NM + gl);
        end

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
